// File: rtl/ujtag_multi.sv
// rtl/ujtag_multi.sv - JTAG TAP with IDCODE, BYPASS and NCH user data-register channels
module ujtag_multi #(
  parameter int          IR_W   = 8,
  parameter int          NCH    = 4,
  parameter int          DR_W   = 32,
  parameter logic [31:0] IDCODE = 32'h0000_0001
) (
  input  logic                TCK,
  input  logic                URST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_OE,
  output logic [IR_W-1:0]     UIREG,
  output logic [3:0]          TAP_STATE,
  input  logic [NCH*DR_W-1:0] DR_CAP_DATA,
  output logic [NCH*DR_W-1:0] DR_UPD_DATA,
  output logic [NCH-1:0]      DR_UPD_STB
);

  localparam int              CH_W      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IR_W-1:0] OP_IDCODE = {{(IR_W-1){1'b1}}, 1'b0};
  localparam logic [IR_W-1:0] NCH_L     = IR_W'(NCH);

  typedef enum logic [3:0] {
    EX2_DR   = 4'h0, EX1_DR   = 4'h1, SH_DR  = 4'h2, PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4, UPD_DR   = 4'h5, CAP_DR = 4'h6, SEL_DR   = 4'h7,
    EX2_IR   = 4'h8, EX1_IR   = 4'h9, SH_IR  = 4'hA, PAUSE_IR = 4'hB,
    RTI      = 4'hC, UPD_IR   = 4'hD, CAP_IR = 4'hE, TLR      = 4'hF
  } tap_t;

  typedef enum logic [1:0] {SEL_USER, SEL_ID, SEL_BP} sel_t;

  tap_t                r_state;
  tap_t                w_next;
  logic [IR_W-1:0]     r_ir_sh;
  logic [IR_W-1:0]     r_uireg;
  logic [DR_W-1:0]     r_dr_sh;
  logic [31:0]         r_id_sh;
  logic                r_bp;
  sel_t                r_sel;
  logic [CH_W-1:0]     r_ch;
  logic [NCH*DR_W-1:0] r_upd;
  logic [NCH-1:0]      r_stb;
  logic                r_tdo;
  logic                r_tdo_oe;
  logic                w_is_user;
  logic                w_is_id;
  logic [CH_W-1:0]     w_cap_ch;
  logic [DR_W-1:0]     w_cap;
  logic                w_dr_bit;

  assign TAP_STATE   = r_state;
  assign UIREG       = r_uireg;
  assign DR_UPD_DATA = r_upd;
  assign DR_UPD_STB  = r_stb;
  assign TDO         = r_tdo;
  assign TDO_OE      = r_tdo_oe;

  assign w_is_user = (r_uireg < NCH_L);
  assign w_is_id   = (r_uireg == OP_IDCODE);
  assign w_cap_ch  = r_uireg[CH_W-1:0];

  // IEEE 1149.1 TAP next-state graph
  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:      w_next = TMS ? TLR    : RTI;
      RTI:      w_next = TMS ? SEL_DR : RTI;
      SEL_DR:   w_next = TMS ? SEL_IR : CAP_DR;
      CAP_DR:   w_next = TMS ? EX1_DR : SH_DR;
      SH_DR:    w_next = TMS ? EX1_DR : SH_DR;
      EX1_DR:   w_next = TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR: w_next = TMS ? EX2_DR : PAUSE_DR;
      EX2_DR:   w_next = TMS ? UPD_DR : SH_DR;
      UPD_DR:   w_next = TMS ? SEL_DR : RTI;
      SEL_IR:   w_next = TMS ? TLR    : CAP_IR;
      CAP_IR:   w_next = TMS ? EX1_IR : SH_IR;
      SH_IR:    w_next = TMS ? EX1_IR : SH_IR;
      EX1_IR:   w_next = TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR: w_next = TMS ? EX2_IR : PAUSE_IR;
      EX2_IR:   w_next = TMS ? UPD_IR : SH_IR;
      UPD_IR:   w_next = TMS ? SEL_DR : RTI;
      default:  w_next = TLR;
    endcase
  end

  // Parallel capture value of the channel addressed by the current instruction
  always_comb begin
    w_cap = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_cap_ch == CH_W'(k)) w_cap = DR_CAP_DATA[k*DR_W +: DR_W];
    end
  end

  // Bit 0 of whichever data register the current scan latched at capture
  always_comb begin
    case (r_sel)
      SEL_USER: w_dr_bit = r_dr_sh[0];
      SEL_ID:   w_dr_bit = r_id_sh[0];
      default:  w_dr_bit = r_bp;
    endcase
  end

  // TAP state register
  always_ff @(posedge TCK or posedge URST) begin
    if (URST) r_state <= TLR;
    else      r_state <= w_next;
  end

  // Shifters, instruction register and channel update registers; updates land on entry to Update-*
  always_ff @(posedge TCK or posedge URST) begin
    if (URST) begin
      r_ir_sh <= '0;
      r_uireg <= OP_IDCODE;
      r_dr_sh <= '0;
      r_id_sh <= '0;
      r_bp    <= 1'b0;
      r_sel   <= SEL_BP;
      r_ch    <= '0;
      r_upd   <= '0;
      r_stb   <= '0;
    end else begin
      r_stb <= '0;
      case (r_state)
        CAP_IR: r_ir_sh <= IR_W'(2'b01);
        SH_IR:  r_ir_sh <= {TDI, r_ir_sh[IR_W-1:1]};
        CAP_DR: begin
          r_ch <= w_cap_ch;
          if (w_is_user) begin
            r_sel   <= SEL_USER;
            r_dr_sh <= w_cap;
          end else if (w_is_id) begin
            r_sel   <= SEL_ID;
            r_id_sh <= IDCODE;
          end else begin
            r_sel <= SEL_BP;
            r_bp  <= 1'b0;
          end
        end
        SH_DR: begin
          case (r_sel)
            SEL_USER: r_dr_sh <= {TDI, r_dr_sh[DR_W-1:1]};
            SEL_ID:   r_id_sh <= {TDI, r_id_sh[31:1]};
            default:  r_bp    <= TDI;
          endcase
        end
        default: ;
      endcase
      if (w_next == UPD_IR) r_uireg <= r_ir_sh;
      if (w_next == TLR)    r_uireg <= OP_IDCODE;
      if (w_next == UPD_DR && r_sel == SEL_USER) begin
        for (int k = 0; k < NCH; k++) begin
          if (r_ch == CH_W'(k)) begin
            r_upd[k*DR_W +: DR_W] <= r_dr_sh;
            r_stb[k]              <= 1'b1;
          end
        end
      end
    end
  end

  // TDO and its enable are launched on the falling edge so the host samples them on the next rise
  always_ff @(negedge TCK or posedge URST) begin
    if (URST) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else begin
      r_tdo_oe <= (r_state == SH_IR) || (r_state == SH_DR);
      if (r_state == SH_IR)      r_tdo <= r_ir_sh[0];
      else if (r_state == SH_DR) r_tdo <= w_dr_bit;
      else                       r_tdo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ujtag_multi.sv
// tb/tb_ujtag_multi.sv - randomized scan bench for ujtag_multi against a queue-based model
module tb_ujtag_multi;

  localparam int S_SHDR = 2, S_UPDDR = 5, S_CAPDR = 6;
  localparam int S_SHIR = 10, S_RTI = 12, S_UPDIR = 13, S_CAPIR = 14, S_TLR = 15;

  logic         TCK = 1'b0;
  logic         URST = 1'b0;
  logic         TMS = 1'b1;
  logic         TDI = 1'b0;
  logic         TDO, TDO_OE;
  logic [7:0]   UIREG;
  logic [3:0]   TAP_STATE;
  logic [127:0] DR_CAP_DATA = '0;
  logic [127:0] DR_UPD_DATA;
  logic [3:0]   DR_UPD_STB;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // 1149.1 state graph indexed by state code: next state for TMS=0 / TMS=1
  int nx0[16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int nx1[16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

  // model state: scans are bit queues, capture bits first then TDI bits appended
  int          m_state;
  logic [7:0]  m_uireg;
  logic [31:0] m_upd[4];
  logic [3:0]  m_stb;
  int          m_kind;
  int          m_ch;
  bit          dq[$];
  bit          iq[$];
  logic        m_tdo, m_oe;

  ujtag_multi #(.IR_W(8), .NCH(4), .DR_W(32), .IDCODE(32'h0000_0001)) dut (
    .TCK(TCK), .URST(URST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_OE(TDO_OE),
    .UIREG(UIREG), .TAP_STATE(TAP_STATE), .DR_CAP_DATA(DR_CAP_DATA),
    .DR_UPD_DATA(DR_UPD_DATA), .DR_UPD_STB(DR_UPD_STB)
  );

  always #5 TCK = ~TCK;

  function automatic logic [31:0] q2v(input bit q[$]);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
    return v;
  endfunction

  task automatic m_reset();
    m_state = S_TLR;
    m_uireg = 8'hFE;
    for (int k = 0; k < 4; k++) m_upd[k] = '0;
    m_stb  = '0;
    m_kind = 2;
    m_ch   = 0;
    dq.delete();
    iq.delete();
    m_tdo = 1'b0;
    m_oe  = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge TCK or posedge URST) begin : model_pos
    int s, ns, w;
    logic [31:0] cap;
    if (URST) begin
      m_reset();
    end else begin
      s  = m_state;
      ns = TMS ? nx1[s] : nx0[s];
      m_stb = '0;
      if (s == S_CAPIR) begin
        iq.delete();
        for (int i = 0; i < 8; i++) iq.push_back(i == 0);
      end else if (s == S_SHIR) begin
        void'(iq.pop_front());
        iq.push_back(TDI);
      end else if (s == S_CAPDR) begin
        if (m_uireg < 8'd4) begin
          m_kind = 0; m_ch = int'(m_uireg); cap = DR_CAP_DATA[m_ch*32 +: 32]; w = 32;
        end else if (m_uireg == 8'hFE) begin
          m_kind = 1; cap = 32'h0000_0001; w = 32;
        end else begin
          m_kind = 2; cap = 32'h0; w = 1;
        end
        dq.delete();
        for (int i = 0; i < w; i++) dq.push_back(cap[i]);
      end else if (s == S_SHDR) begin
        void'(dq.pop_front());
        dq.push_back(TDI);
      end
      if (ns == S_UPDIR) m_uireg = q2v(iq);
      if (ns == S_UPDDR && m_kind == 0) begin
        m_upd[m_ch] = q2v(dq);
        m_stb[m_ch] = 1'b1;
      end
      if (ns == S_TLR) m_uireg = 8'hFE;
      m_state = ns;
    end
  end

  always @(negedge TCK) begin
    if (!URST) begin
      m_oe  = (m_state == S_SHIR) || (m_state == S_SHDR);
      m_tdo = (m_state == S_SHIR) ? iq[0] : (m_state == S_SHDR) ? dq[0] : 1'b0;
    end
  end

  // single compare point per cycle, just after the falling edge
  always @(negedge TCK) begin
    #2;
    if (chk_en) begin
      chk("tap_state", 32'(TAP_STATE), 32'(m_state));
      chk("uireg", 32'(UIREG), 32'(m_uireg));
      chk("tdo", 32'(TDO), 32'(m_tdo));
      chk("tdo_oe", 32'(TDO_OE), 32'(m_oe));
      chk("upd_stb", 32'(DR_UPD_STB), 32'(m_stb));
      for (int k = 0; k < 4; k++) chk("upd_data", DR_UPD_DATA[k*32 +: 32], m_upd[k]);
    end
  end

  task automatic tick(input logic tms, input logic tdi, output logic tdo);
    @(negedge TCK);
    #1;
    TMS = tms;
    TDI = tdi;
    tdo = TDO;
    @(posedge TCK);
    #1;
  endtask

  task automatic ir_scan(input logic [7:0] op, output logic [7:0] out);
    logic b;
    out = '0;
    tick(1'b1, 1'b0, b); tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b); tick(1'b0, 1'b0, b);
    for (int i = 0; i < 8; i++) begin
      tick(i == 7, op[i], b);
      out[i] = b;
    end
    tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b);
  endtask

  task automatic dr_scan(input int n, input logic [39:0] val, input int pause_at,
                         output logic [39:0] out, output logic [3:0] stb_upd,
                         output logic [3:0] stb_after);
    logic b;
    out = '0;
    tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b); tick(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      if (i == pause_at && i != n - 1) begin
        tick(1'b1, val[i], b);
        out[i] = b;
        tick(1'b0, 1'b0, b); tick(1'b0, 1'b0, b); tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b);
      end else begin
        tick(i == n - 1, val[i], b);
        out[i] = b;
      end
    end
    tick(1'b1, 1'b0, b);
    stb_upd = DR_UPD_STB;
    tick(1'b0, 1'b0, b);
    stb_after = DR_UPD_STB;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ir_out;
    logic [39:0] dr_out;
    logic [3:0]  s_upd, s_aft;
    logic        b;
    logic [7:0]  op;

    DR_CAP_DATA = {$urandom, $urandom, $urandom, $urandom};
    DR_CAP_DATA[64 +: 32] = 32'h1234_5678;
    #2 URST = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge TCK); #1;
    chk("rst_tap", 32'(TAP_STATE), 32'hF);
    chk("rst_uireg", 32'(UIREG), 32'hFE);
    chk("rst_oe", 32'(TDO_OE), 32'h0);
    chk("rst_upd", DR_UPD_DATA[31:0] | DR_UPD_DATA[63:32] | DR_UPD_DATA[95:64] | DR_UPD_DATA[127:96], 32'h0);
    @(negedge TCK); #1 URST = 1'b0;

    tick(1'b0, 1'b0, b);
    chk("idle_tap", 32'(TAP_STATE), 32'hC);
    chk("idle_uireg", 32'(UIREG), 32'hFE);
    chk("idle_oe", 32'(TDO_OE), 32'h0);

    ir_scan(8'h02, ir_out);
    chk("ch2_ir_cap", 32'(ir_out), 32'h01);
    dr_scan(32, 40'hDE_ADBE_EF, 13, dr_out, s_upd, s_aft);
    chk("ch2_tdo", dr_out[31:0], 32'h1234_5678);
    chk("ch2_upd", DR_UPD_DATA[64 +: 32], 32'hDEAD_BEEF);
    chk("ch2_stb", 32'(s_upd), 32'h4);
    chk("ch2_stb_after", 32'(s_aft), 32'h0);
    chk("ch013_hold", DR_UPD_DATA[0 +: 32] | DR_UPD_DATA[32 +: 32] | DR_UPD_DATA[96 +: 32], 32'h0);

    ir_scan(8'hFF, ir_out);
    chk("byp_ir_cap", 32'(ir_out), 32'h01);
    chk("byp_uireg", 32'(UIREG), 32'hFF);
    dr_scan(8, 40'hA5, -1, dr_out, s_upd, s_aft);
    chk("byp_tdo", dr_out[31:0], 32'h4A);
    chk("byp_stb", 32'(s_upd), 32'h0);

    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, b);
    tick(1'b0, 1'b0, b);
    dr_scan(32, {8'h0, $urandom}, -1, dr_out, s_upd, s_aft);
    chk("id_tdo", dr_out[31:0], 32'h0000_0001);
    chk("id_stb", 32'(s_upd), 32'h0);

    tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b); tick(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'($urandom), b);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, b);
    chk("tlr5_tap", 32'(TAP_STATE), 32'hF);
    chk("tlr5_uireg", 32'(UIREG), 32'hFE);
    chk("tlr5_upd", DR_UPD_DATA[64 +: 32], 32'hDEAD_BEEF);
    tick(1'b0, 1'b0, b);

    ir_scan(8'h01, ir_out);
    tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b); tick(1'b0, 1'b0, b);
    for (int i = 0; i < 9; i++) tick(1'b0, 1'($urandom), b);
    @(negedge TCK); #1 URST = 1'b1;
    @(negedge TCK); #1;
    chk("abort_tap", 32'(TAP_STATE), 32'hF);
    chk("abort_stb", 32'(DR_UPD_STB), 32'h0);
    chk("abort_ch1", DR_UPD_DATA[32 +: 32], 32'h0);
    URST = 1'b0;
    tick(1'b0, 1'b0, b);

    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0) DR_CAP_DATA = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 4))
        0, 1: begin
          case ($urandom_range(0, 6))
            0, 1, 2, 3: op = 8'($urandom_range(0, 3));
            4:          op = 8'hFE;
            5:          op = 8'hFF;
            default:    op = 8'($urandom);
          endcase
          ir_scan(op, ir_out);
        end
        2, 3: begin
          dr_scan($urandom_range(1, 40), {8'($urandom), $urandom},
                  ($urandom_range(0, 1) == 1) ? $urandom_range(0, 39) : -1,
                  dr_out, s_upd, s_aft);
        end
        default: begin
          for (int i = 0; i < 20; i++) tick(($urandom_range(0, 2) == 0), 1'($urandom), b);
          if ($urandom_range(0, 2) == 0) begin
            @(negedge TCK); #1 URST = 1'b1;
            @(negedge TCK); #1 URST = 1'b0;
          end
          for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, b);
          tick(1'b0, 1'b0, b);
        end
      endcase
    end

    repeat (2) @(negedge TCK);
    #4;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
